// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite initiator.
// Turns a valid/ready command stream into one AXI4-Lite read or write and
// returns one response per command. A per-transaction watchdog flags a
// slave that stalls too long without aborting the transfer.
module axi_lite_cmd_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_TIMEOUT          = 1024
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESET,
   // command stream
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   // response stream
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic                              rsp_write,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              timeout_err,
   // AXI4-Lite write address
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   // AXI4-Lite write data
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   // AXI4-Lite write response
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   // AXI4-Lite read address
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   // AXI4-Lite read data
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int C_STRB_W = C_M_AXI_DATA_WIDTH / 8;
   // The flag is raised on entering the C_TIMEOUT-th cycle after acceptance,
   // i.e. when the count of completed busy cycles reaches C_TIMEOUT-1.
   localparam logic [15:0] C_TO_M1 = 16'(C_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_DATA,
      S_RESP
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;

   logic                            r_cmd_ready;
   logic                            r_awvalid;
   logic                            r_wvalid;
   logic                            r_bready;
   logic                            r_arvalid;
   logic                            r_rready;
   logic                            r_rsp_valid;

   logic                            r_write;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
   logic [C_STRB_W-1:0]             r_wstrb;

   logic                            r_rsp_write;
   logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [1:0]                      r_rsp_resp;

   logic [15:0]                     r_wd_cnt;
   logic [15:0]                     w_wd_cnt_nxt;
   logic                            r_timeout_err;

   logic                            w_cmd_acc;
   logic                            w_aw_ok;
   logic                            w_w_ok;
   logic                            w_busy;

   assign w_cmd_acc = cmd_valid & r_cmd_ready;
   // a channel is finished once its VALID has dropped or it handshakes now
   assign w_aw_ok   = ~r_awvalid | M_AXI_AWREADY;
   assign w_w_ok    = ~r_wvalid  | M_AXI_WREADY;
   assign w_busy    = (r_state == S_WR_REQ) | (r_state == S_WR_RESP) |
                      (r_state == S_RD_REQ) | (r_state == S_RD_DATA);

   // next-state decode and saturating watchdog increment
   always_comb begin
      w_state_nxt  = r_state;
      w_wd_cnt_nxt = (r_wd_cnt == 16'hFFFF) ? r_wd_cnt : r_wd_cnt + 16'd1;
      case (r_state)
         S_IDLE:    if (w_cmd_acc)               w_state_nxt = cmd_write ? S_WR_REQ : S_RD_REQ;
         S_WR_REQ:  if (w_aw_ok && w_w_ok)       w_state_nxt = S_WR_RESP;
         S_WR_RESP: if (M_AXI_BVALID)            w_state_nxt = S_RESP;
         S_RD_REQ:  if (M_AXI_ARREADY)           w_state_nxt = S_RD_DATA;
         S_RD_DATA: if (M_AXI_RVALID)            w_state_nxt = S_RESP;
         S_RESP:    if (rsp_ready)               w_state_nxt = S_IDLE;
         default:                                w_state_nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) r_state <= S_IDLE;
      else              r_state <= w_state_nxt;
   end

   // registered handshake outputs derived from the upcoming state
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         r_cmd_ready <= 1'b1;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_cmd_ready <= (w_state_nxt == S_IDLE);
         // AW and W drop independently, each right after its own handshake
         r_awvalid   <= (w_state_nxt == S_WR_REQ) &
                        ((r_state == S_IDLE) | (r_awvalid & ~M_AXI_AWREADY));
         r_wvalid    <= (w_state_nxt == S_WR_REQ) &
                        ((r_state == S_IDLE) | (r_wvalid & ~M_AXI_WREADY));
         r_bready    <= (w_state_nxt == S_WR_RESP);
         r_arvalid   <= (w_state_nxt == S_RD_REQ);
         r_rready    <= (w_state_nxt == S_RD_DATA);
         r_rsp_valid <= (w_state_nxt == S_RESP);
      end
   end

   // command payload latch, held stable for the whole transaction
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if (w_cmd_acc) begin
         r_write <= cmd_write;
         r_addr  <= cmd_addr;
         r_wdata <= cmd_wdata;
         r_wstrb <= cmd_wstrb;
      end
   end

   // response capture from B or R, held until the response is consumed
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
      end else if ((r_state == S_WR_RESP) && M_AXI_BVALID) begin
         r_rsp_write <= r_write;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= M_AXI_BRESP;
      end else if ((r_state == S_RD_DATA) && M_AXI_RVALID) begin
         r_rsp_write <= r_write;
         r_rsp_rdata <= M_AXI_RDATA;
         r_rsp_resp  <= M_AXI_RRESP;
      end
   end

   // watchdog: counts busy cycles, flag sticky until the next command
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else if (w_cmd_acc) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= (C_TIMEOUT == 1);
      end else if (w_busy) begin
         r_wd_cnt <= w_wd_cnt_nxt;
         // not raised if the transfer completes on this very edge
         if ((w_wd_cnt_nxt == C_TO_M1) && (w_state_nxt != S_RESP))
            r_timeout_err <= 1'b1;
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_write     = r_rsp_write;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign timeout_err   = r_timeout_err;

   assign M_AXI_AWADDR  = r_addr;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = r_wstrb;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;

endmodule
